// File: rtl/four_bit_cnt_ctrl_if.sv
// Control/status bundle for the four-bit step counter: requests and
// configuration flow master->slave, count and pulses flow slave->master.
interface four_bit_cnt_ctrl_if;
  logic       start;
  logic       stop;
  logic       pause;
  logic       auto_reload;
  logic       up_down;
  logic [3:0] load_val;
  logic [3:0] term_val;
  logic [3:0] q;
  logic       busy;
  logic       done;
  logic       wrap;
  logic [1:0] dbg_state;

  modport master (
    output start, stop, pause, auto_reload, up_down, load_val, term_val,
    input  q, busy, done, wrap, dbg_state
  );

  modport slave (
    input  start, stop, pause, auto_reload, up_down, load_val, term_val,
    output q, busy, done, wrap, dbg_state
  );
endinterface

// File: rtl/four_bit_cnt_ctrl.sv
// Four-bit up/down counter stepping once every DIV clocks, with start/stop/pause
// control, one-shot or auto-reload at a terminal value, and done/wrap pulses.
module four_bit_cnt_ctrl #(
  parameter int DIV = 1
) (
  input  logic               clk,
  input  logic               reset,
  four_bit_cnt_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam logic [3:0] DIV_M1 = 4'(DIV - 1);

  state_e     state_q, state_d;
  logic [3:0] q_q, q_d;
  logic [3:0] presc_q, presc_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       wrap_q, wrap_d;

  logic       start_go;
  logic       start_hit;
  logic       tick;
  logic       at_term;
  logic       arrive;
  logic [3:0] step_val;

  // stop outranks everything, so it masks both start and tick here
  assign start_go  = (state_q == IDLE) && bus.start && !bus.stop;
  assign start_hit = start_go && (bus.load_val == bus.term_val);
  assign tick      = (state_q == RUN) && !bus.stop && !bus.pause && (presc_q == DIV_M1);
  assign at_term   = (q_q == bus.term_val);
  assign step_val  = bus.up_down ? (q_q + 4'd1) : (q_q - 4'd1);
  assign arrive    = tick && !at_term && (step_val == bus.term_val);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.stop) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (start_go) state_d = (start_hit && !bus.auto_reload) ? IDLE : RUN;
        RUN: begin
          if (bus.pause)                       state_d = HOLD;
          else if (arrive && !bus.auto_reload) state_d = IDLE;
        end
        HOLD:    if (!bus.pause) state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // Reaching term_val on a tick arms the reload; the following tick reloads quietly.
  always_comb begin
    q_d     = q_q;
    presc_d = presc_q;
    done_d  = 1'b0;
    wrap_d  = 1'b0;
    if (bus.stop) begin
      presc_d = 4'd0;
    end else if (start_go) begin
      q_d     = bus.load_val;
      presc_d = 4'd0;
      done_d  = start_hit;
    end else if ((state_q == RUN) && !bus.pause) begin
      if (tick) begin
        presc_d = 4'd0;
        if (at_term) begin
          q_d = bus.load_val;
        end else begin
          q_d    = step_val;
          done_d = arrive;
          wrap_d = bus.up_down ? (q_q == 4'd15) : (q_q == 4'd0);
        end
      end else begin
        presc_d = presc_q + 4'd1;
      end
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q     <= 4'd0;
      presc_q <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      q_q     <= q_d;
      presc_q <= presc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.q         = q_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.wrap      = wrap_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_four_bit_cnt_ctrl.sv
// Bench for four_bit_cnt_ctrl: three instances (DIV=1,3,4) share one stimulus
// stream; a queue of expected per-edge outputs is drained by a monitor.
module tb_four_bit_cnt_ctrl;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam int W = 11;

  logic       clk;
  logic       reset;
  logic       start, stop, pause, auto_reload, up_down;
  logic [3:0] load_val, term_val;

  four_bit_cnt_ctrl_if if0 ();
  four_bit_cnt_ctrl_if if1 ();
  four_bit_cnt_ctrl_if if2 ();

  assign if0.start = start;        assign if1.start = start;        assign if2.start = start;
  assign if0.stop = stop;          assign if1.stop = stop;          assign if2.stop = stop;
  assign if0.pause = pause;        assign if1.pause = pause;        assign if2.pause = pause;
  assign if0.auto_reload = auto_reload;
  assign if1.auto_reload = auto_reload;
  assign if2.auto_reload = auto_reload;
  assign if0.up_down = up_down;    assign if1.up_down = up_down;    assign if2.up_down = up_down;
  assign if0.load_val = load_val;  assign if1.load_val = load_val;  assign if2.load_val = load_val;
  assign if0.term_val = term_val;  assign if1.term_val = term_val;  assign if2.term_val = term_val;

  four_bit_cnt_ctrl #(.DIV(1)) u_div1 (.clk(clk), .reset(reset), .bus(if0.slave));
  four_bit_cnt_ctrl #(.DIV(3)) u_div3 (.clk(clk), .reset(reset), .bus(if1.slave));
  four_bit_cnt_ctrl #(.DIV(4)) u_div4 (.clk(clk), .reset(reset), .bus(if2.slave));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  // entry = {dut[1:0], state[1:0], busy, done, wrap, q[3:0]}
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           total = 0;
  int           bad   = 0;
  event         chk_ev;

  logic [W-1:0] mon_e;
  logic [8:0]   mon_act;
  string        mon_nm;

  initial begin
    forever begin
      @(posedge clk or chk_ev);
      #1;
      while (exp_q.size() > 0) begin
        mon_e  = exp_q.pop_front();
        mon_nm = name_q.pop_front();
        case (mon_e[10:9])
          2'd0:    mon_act = {if0.dbg_state, if0.busy, if0.done, if0.wrap, if0.q};
          2'd1:    mon_act = {if1.dbg_state, if1.busy, if1.done, if1.wrap, if1.q};
          default: mon_act = {if2.dbg_state, if2.busy, if2.done, if2.wrap, if2.q};
        endcase
        total++;
        if (mon_act !== mon_e[8:0]) begin
          bad++;
          $display("FAIL %s dut%0d t=%0t: got st=%0d busy=%0b done=%0b wrap=%0b q=%0d, want st=%0d busy=%0b done=%0b wrap=%0b q=%0d",
                   mon_nm, mon_e[10:9], $time, mon_act[8:7], mon_act[6], mon_act[5], mon_act[4], mon_act[3:0],
                   mon_e[8:7], mon_e[6], mon_e[5], mon_e[4], mon_e[3:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic push(input logic [1:0] d, input logic [1:0] st, input logic b,
                      input logic dn, input logic w, input logic [3:0] qv, input string nm);
    exp_q.push_back({d, st, b, dn, w, qv});
    name_q.push_back(nm);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    start = 1'b0; stop = 1'b0; pause = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  task automatic setup(input logic [3:0] ld, input logic [3:0] tv, input logic up, input logic ar);
    load_val = ld; term_val = tv; up_down = up; auto_reload = ar;
  endtask

  // ---------------- stimulus ----------------
  logic [3:0] qb [16];

  initial begin
    reset = 1'b0;
    idle_inputs();
    setup(4'd0, 4'd0, 1'b1, 1'b0);
    repeat (2) step();

    // reset state on every instance
    for (int d = 0; d < 3; d++) push(2'(d), S_IDLE, 0, 0, 0, 4'd0, "reset_state");
    step();
    reset = 1'b1;

    // DIV=1 one-shot up 2..5
    setup(4'd2, 4'd5, 1'b1, 1'b0);
    start = 1'b1;
    push(0, S_RUN, 1, 0, 0, 4'd2, "up_oneshot_start"); step(); start = 1'b0;
    push(0, S_RUN, 1, 0, 0, 4'd3, "up_oneshot_q3"); step();
    push(0, S_RUN, 1, 0, 0, 4'd4, "up_oneshot_q4"); step();
    push(0, S_IDLE, 0, 1, 0, 4'd5, "up_oneshot_done"); step();
    push(0, S_IDLE, 0, 0, 0, 4'd5, "up_oneshot_after"); step();
    do_reset();

    // DIV=3 auto-reload up 14 -> 1 with wrap and reload
    setup(4'd14, 4'd1, 1'b1, 1'b1);
    qb = '{4'd14, 4'd14, 4'd14, 4'd15, 4'd15, 4'd15, 4'd0, 4'd0,
           4'd0, 4'd1, 4'd1, 4'd1, 4'd14, 4'd14, 4'd14, 4'd15};
    start = 1'b1;
    for (int i = 0; i < 16; i++) begin
      push(1, S_RUN, 1, (i == 9), (i == 6), qb[i], "div3_reload");
      step();
      start = 1'b0;
    end
    do_reset();

    // DIV=1 one-shot down 0 -> 12 through wrap
    setup(4'd0, 4'd12, 1'b0, 1'b0);
    start = 1'b1;
    push(0, S_RUN, 1, 0, 0, 4'd0, "down_start"); step(); start = 1'b0;
    push(0, S_RUN, 1, 0, 1, 4'd15, "down_wrap"); step();
    push(0, S_RUN, 1, 0, 0, 4'd14, "down_q14"); step();
    push(0, S_RUN, 1, 0, 0, 4'd13, "down_q13"); step();
    push(0, S_IDLE, 0, 1, 0, 4'd12, "down_done"); step();
    push(0, S_IDLE, 0, 0, 0, 4'd12, "down_idle"); step();
    do_reset();

    // DIV=4 pause mid-step: prescaler frozen at 1, three more clocks after resume
    setup(4'd3, 4'd10, 1'b1, 1'b0);
    start = 1'b1;
    push(2, S_RUN, 1, 0, 0, 4'd3, "pause_start"); step(); start = 1'b0;
    push(2, S_RUN, 1, 0, 0, 4'd3, "pause_presc1"); step();
    pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push(2, S_HOLD, 1, 0, 0, 4'd3, "pause_hold"); step();
    end
    pause = 1'b0;
    push(2, S_RUN, 1, 0, 0, 4'd3, "pause_resume"); step();
    push(2, S_RUN, 1, 0, 0, 4'd3, "pause_presc2"); step();
    push(2, S_RUN, 1, 0, 0, 4'd3, "pause_presc3"); step();
    push(2, S_RUN, 1, 0, 0, 4'd4, "pause_step"); step();
    do_reset();

    // start+stop together in IDLE, then stop mid-run at q=7
    setup(4'd9, 4'd12, 1'b1, 1'b0);
    start = 1'b1; stop = 1'b1;
    push(0, S_IDLE, 0, 0, 0, 4'd0, "start_stop_same"); step();
    stop = 1'b0; load_val = 4'd4;
    push(0, S_RUN, 1, 0, 0, 4'd4, "stop_run_start"); step(); start = 1'b0;
    push(0, S_RUN, 1, 0, 0, 4'd5, "stop_run_q5"); step();
    push(0, S_RUN, 1, 0, 0, 4'd6, "stop_run_q6"); step();
    push(0, S_RUN, 1, 0, 0, 4'd7, "stop_run_q7"); step();
    stop = 1'b1;
    push(0, S_IDLE, 0, 0, 0, 4'd7, "stop_abort"); step();
    stop = 1'b0;
    push(0, S_IDLE, 0, 0, 0, 4'd7, "stop_hold_q"); step();
    do_reset();

    // asynchronous reset while running at q=9
    setup(4'd7, 4'd12, 1'b1, 1'b0);
    start = 1'b1;
    push(0, S_RUN, 1, 0, 0, 4'd7, "areset_q7"); step(); start = 1'b0;
    push(0, S_RUN, 1, 0, 0, 4'd8, "areset_q8"); step();
    push(0, S_RUN, 1, 0, 0, 4'd9, "areset_q9"); step();
    #2;
    reset = 1'b0;
    for (int d = 0; d < 3; d++) push(2'(d), S_IDLE, 0, 0, 0, 4'd0, "areset_async");
    -> chk_ev;
    step();
    reset = 1'b1;

    // load_val == term_val start: one-shot stays IDLE, auto-reload keeps running
    setup(4'd6, 4'd6, 1'b1, 1'b0);
    start = 1'b1;
    push(0, S_IDLE, 0, 1, 0, 4'd6, "eq_oneshot_done"); step(); start = 1'b0;
    push(0, S_IDLE, 0, 0, 0, 4'd6, "eq_oneshot_after"); step();
    auto_reload = 1'b1; start = 1'b1;
    push(0, S_RUN, 1, 1, 0, 4'd6, "eq_auto_done"); step(); start = 1'b0;
    push(0, S_RUN, 1, 0, 0, 4'd6, "eq_auto_reload"); step();
    push(0, S_RUN, 1, 0, 0, 4'd6, "eq_auto_reload2"); step();
    do_reset();

    // step that wraps onto term_val raises done and wrap together
    setup(4'd14, 4'd0, 1'b1, 1'b0);
    start = 1'b1;
    push(0, S_RUN, 1, 0, 0, 4'd14, "wrap_term_start"); step(); start = 1'b0;
    push(0, S_RUN, 1, 0, 0, 4'd15, "wrap_term_q15"); step();
    push(0, S_IDLE, 0, 1, 1, 4'd0, "wrap_term_both"); step();
    do_reset();

    // direction change mid-run applies on the next tick
    setup(4'd5, 4'd15, 1'b1, 1'b1);
    start = 1'b1;
    push(0, S_RUN, 1, 0, 0, 4'd5, "dir_start"); step(); start = 1'b0;
    push(0, S_RUN, 1, 0, 0, 4'd6, "dir_up"); step();
    up_down = 1'b0;
    push(0, S_RUN, 1, 0, 0, 4'd5, "dir_down1"); step();
    push(0, S_RUN, 1, 0, 0, 4'd4, "dir_down2"); step();
    do_reset();

    repeat (2) step();
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending entries, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
